seq_detect_fsm: RTL

Parametrised serial pattern detector built on a one-hot state machine, generalising the fixed three-state idle/s0/s1 FSM to an arbitrary PAT_W-bit pattern. It samples one qualified bit per cycle from din, tracks the longest matched prefix, and pulses dout on every full match. A runtime overlap/non-overlap mode selects the post-match state, and a saturating counter accumulates matches. It sits between a serial bit source and control logic; its state vector is exported so benches can check encoding properties directly.

---
 rtl/seq_detect_fsm.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/seq_detect_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detect_fsm
//  Purpose  : Serial pattern detector for a PAT_W-bit PATTERN (MSB received
//             first). Consumes one qualified bit per cycle, tracks the longest
//             matched prefix in a one-hot state vector, pulses dout on every
//             full match and keeps a saturating match counter. A runtime
//             overlap input selects whether a match may share bits with the
//             next one.
//  Ports    : clk        - clock, rising edge
//             rst        - synchronous active-high reset
//             din        - serial data bit
//             din_valid  - din consumed this cycle when high
//             overlap    - 1: overlapping matches, 0: restart after a match
//             clr_cnt    - synchronous clear of match_cnt
//             dout       - registered one-cycle match pulse
//             match_cnt  - registered saturating match count
//             state      - registered one-hot state (bit0 IDLE, bit k+1 M_k)
//  Revision : 1.0 - initial release
// ============================================================================
module seq_detect_fsm #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             overlap,
    input  logic             clr_cnt,
    output logic             dout,
    output logic [CNT_W-1:0] match_cnt,
    output logic [PAT_W:0]   state
);

    // ------------------------------------------------------------------------
    // Parameter legality
    // ------------------------------------------------------------------------
    generate
        if (PAT_W < 2 || PAT_W > 32) begin : g_bad_pat_w
            $error("seq_detect_fsm: PAT_W must be in 2..32");
        end
        if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
            $error("seq_detect_fsm: CNT_W must be in 1..32");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Elaboration-time transition table
    // ------------------------------------------------------------------------
    // Bit idx of PATTERN in arrival order (idx 0 = first bit received).
    function automatic logic f_pbit(input int idx);
        logic [PAT_W-1:0] v;
        v = PATTERN >> (PAT_W - 1 - idx);
        return v[0];
    endfunction

    // From M_k on bit b: longest suffix of (prefix_k, b) that is also a
    // prefix of PATTERN, capped at PAT_W-1. For k = PAT_W-1 and b equal to
    // the last pattern bit this is the longest proper border, i.e. the
    // overlapping post-match state.
    function automatic int f_next(input int k, input logic b);
        int   lim;
        int   res;
        int   sidx;
        logic ok;
        logic sb;
        lim = (k + 1 < PAT_W - 1) ? k + 1 : PAT_W - 1;
        res = 0;
        for (int len = 1; len < PAT_W; len++) begin
            ok = (len <= lim);
            for (int t = 0; t < len; t++) begin
                sidx = k + 1 - len + t;
                sb   = (sidx == k) ? b : f_pbit(sidx);
                if (sb != f_pbit(t)) begin
                    ok = 1'b0;
                end
            end
            if (ok) begin
                res = len;
            end
        end
        return res;
    endfunction

    // Mask of source states M_k that move to M_d when bit b is consumed.
    function automatic logic [PAT_W-1:0] f_src_mask(input int d, input logic b);
        logic [PAT_W-1:0] m;
        m = '0;
        for (int k = 0; k < PAT_W; k++) begin
            if (f_next(k, b) == d) begin
                m = m | (PAT_W'(1) << k);
            end
        end
        return m;
    endfunction

    localparam logic [PAT_W:0]   c_idle_oh  = (PAT_W+1)'(1);
    localparam logic [PAT_W:0]   c_m0_oh    = (PAT_W+1)'(2);
    localparam logic             c_last     = PATTERN[0];
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_max  = '1;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [PAT_W:0]   r_state;
    logic             r_dout;
    logic [CNT_W-1:0] r_cnt;
    logic [PAT_W:0]   w_state_nxt;
    logic [PAT_W-1:0] w_goto;
    logic             w_hit;
    logic             w_legal;

    // w_goto[d]: some active match state moves to M_d on the consumed bit.
    generate
        for (genvar d = 0; d < PAT_W; d++) begin : g_goto
            localparam logic [PAT_W-1:0] c_src0 = f_src_mask(d, 1'b0);
            localparam logic [PAT_W-1:0] c_src1 = f_src_mask(d, 1'b1);
            assign w_goto[d] = din_valid &
                               (|(r_state[PAT_W:1] & (din ? c_src1 : c_src0)));
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Next-state and hit logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = '0;
        w_legal     = $onehot(r_state);
        // Being in M_{PAT_W-1} guarantees the first PAT_W-1 bits already
        // match, so only the incoming bit needs comparing.
        w_hit       = w_legal & r_state[PAT_W] & din_valid & (din == c_last);

        w_state_nxt[PAT_W:1] = (r_state[PAT_W:1] & {PAT_W{~din_valid}}) | w_goto;

        // IDLE always leaves to M0; a non-overlapping hit restarts at M0
        // (w_goto would otherwise point at the border state). A corrupted
        // state vector also recovers to M0.
        if (r_state[0] || (w_hit && !overlap) || !w_legal) begin
            w_state_nxt = c_m0_oh;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle_oh;
            r_dout  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dout  <= w_hit;
            if (clr_cnt) begin
                r_cnt <= w_hit ? c_cnt_one : '0;
            end else if (w_hit && (r_cnt != c_cnt_max)) begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end
    end

    assign state     = r_state;
    assign dout      = r_dout;
    assign match_cnt = r_cnt;

endmodule
`default_nettype wire
